// File: rtl/wave_pkg.sv
// Shared widths, FSM encoding and min/max reset constants for the wave capture block.
package wave_pkg;

   localparam int WAVE_DATA_W = 8;
   localparam int WAVE_ADDR_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [WAVE_DATA_W-1:0] MIN_INIT = '1;
   localparam logic [WAVE_DATA_W-1:0] MAX_INIT = '0;

endpackage

// File: rtl/wave_capture_if.sv
// Sample stream, control and readback signals of wave_capture; i_/o_ are seen from the capture block.
interface wave_capture_if
   import wave_pkg::*;
#(
   parameter int DATA_W = WAVE_DATA_W,
   parameter int ADDR_W = WAVE_ADDR_W
);
   logic              i_sample_valid;
   logic [DATA_W-1:0] i_sample_in;
   logic [ADDR_W-1:0] i_sample_addr;
   logic              i_sample_wrap;
   logic              i_arm;
   logic              i_abort;
   logic [DATA_W-1:0] i_trig_level;
   logic              i_trig_falling;
   logic [ADDR_W-1:0] i_rd_addr;
   logic [DATA_W-1:0] o_rd_data;
   logic              o_busy;
   logic              o_done;
   logic              o_timeout;
   logic [DATA_W-1:0] o_min_val;
   logic [DATA_W-1:0] o_max_val;
   logic [ADDR_W-1:0] o_trig_addr;

   modport master (
      output i_sample_valid, i_sample_in, i_sample_addr, i_sample_wrap,
             i_arm, i_abort, i_trig_level, i_trig_falling, i_rd_addr,
      input  o_rd_data, o_busy, o_done, o_timeout, o_min_val, o_max_val, o_trig_addr
   );

   modport slave (
      input  i_sample_valid, i_sample_in, i_sample_addr, i_sample_wrap,
             i_arm, i_abort, i_trig_level, i_trig_falling, i_rd_addr,
      output o_rd_data, o_busy, o_done, o_timeout, o_min_val, o_max_val, o_trig_addr
   );

endinterface

// File: rtl/wave_buf.sv
// Simple dual-port capture RAM: synchronous write, registered read returning old data on collision.
module wave_buf
   import wave_pkg::*;
#(
   parameter int DATA_W = WAVE_DATA_W,
   parameter int ADDR_W = WAVE_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // NOTE: the array has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) o_rdata <= '0;
      else     o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/wave_capture.sv
// Arms, waits for a level crossing, then captures DEPTH samples with min/max and trigger address.
module wave_capture
   import wave_pkg::*;
#(
   parameter int DATA_W        = WAVE_DATA_W,
   parameter int ADDR_W        = WAVE_ADDR_W,
   parameter int TIMEOUT_WRAPS = 4
) (
   input  logic          clk,
   input  logic          rst,
   wave_capture_if.slave cap_if
);
   localparam int WRAP_W = $clog2(TIMEOUT_WRAPS + 1);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [DATA_W-1:0] r_prev_sample;
   logic              r_prev_valid;
   logic [WRAP_W-1:0] r_wrap_cnt;
   logic              r_timeout;
   logic [DATA_W-1:0] r_min;
   logic [DATA_W-1:0] r_max;
   logic [ADDR_W-1:0] r_trig_addr;

   logic              w_rise, w_fall, w_trig, w_wrap_evt;
   logic              w_clear, w_we, w_first, w_wrap_inc, w_timeout_set, w_prev_upd;
   logic [ADDR_W-1:0] w_waddr;

   assign w_rise = (r_prev_sample <  cap_if.i_trig_level) && (cap_if.i_sample_in >= cap_if.i_trig_level);
   assign w_fall = (r_prev_sample >= cap_if.i_trig_level) && (cap_if.i_sample_in <  cap_if.i_trig_level);
   assign w_trig = cap_if.i_sample_valid && r_prev_valid && (cap_if.i_trig_falling ? w_fall : w_rise);
   assign w_wrap_evt = cap_if.i_sample_valid && cap_if.i_sample_wrap;
   // The trigger sample always lands at index 0.
   assign w_waddr = w_first ? '0 : r_wr_ptr;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      w_state_nxt   = r_state;
      w_clear       = 1'b0;
      w_we          = 1'b0;
      w_first       = 1'b0;
      w_wrap_inc    = 1'b0;
      w_timeout_set = 1'b0;
      w_prev_upd    = 1'b0;
      if (cap_if.i_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (cap_if.i_arm) begin
                  w_state_nxt = ST_ARMED;
                  w_clear     = 1'b1;
               end
            end
            ST_ARMED: begin
               w_prev_upd = cap_if.i_sample_valid;
               if (w_trig) begin
                  w_we        = 1'b1;
                  w_first     = 1'b1;
                  w_state_nxt = ST_CAPTURE;
               end else if (w_wrap_evt) begin
                  w_wrap_inc = 1'b1;
                  if (r_wrap_cnt == WRAP_W'(TIMEOUT_WRAPS - 1)) begin
                     w_state_nxt   = ST_IDLE;
                     w_timeout_set = 1'b1;
                  end
               end
            end
            ST_CAPTURE: begin
               if (cap_if.i_sample_valid) begin
                  w_we = 1'b1;
                  if (r_wr_ptr == '1) w_state_nxt = ST_DONE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_prev_sample <= '0;
         r_prev_valid  <= 1'b0;
         r_wrap_cnt    <= '0;
         r_timeout     <= 1'b0;
         r_min         <= DATA_W'(MIN_INIT);
         r_max         <= DATA_W'(MAX_INIT);
         r_trig_addr   <= '0;
      end else begin
         if (w_clear) begin
            r_wr_ptr     <= '0;
            r_prev_valid <= 1'b0;
            r_wrap_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_min        <= DATA_W'(MIN_INIT);
            r_max        <= DATA_W'(MAX_INIT);
         end
         if (w_prev_upd) begin
            r_prev_sample <= cap_if.i_sample_in;
            r_prev_valid  <= 1'b1;
         end
         if (w_wrap_inc)    r_wrap_cnt  <= r_wrap_cnt + WRAP_W'(1);
         if (w_timeout_set) r_timeout   <= 1'b1;
         if (w_first)       r_trig_addr <= cap_if.i_sample_addr;
         if (w_we) begin
            r_wr_ptr <= w_waddr + ADDR_W'(1);
            r_min    <= (cap_if.i_sample_in < r_min) ? cap_if.i_sample_in : r_min;
            r_max    <= (cap_if.i_sample_in > r_max) ? cap_if.i_sample_in : r_max;
         end
      end
   end

   wave_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (cap_if.i_sample_in),
      .i_raddr (cap_if.i_rd_addr),
      .o_rdata (cap_if.o_rd_data)
   );

   assign cap_if.o_busy      = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
   assign cap_if.o_done      = (r_state == ST_DONE);
   assign cap_if.o_timeout   = r_timeout;
   assign cap_if.o_min_val   = r_min;
   assign cap_if.o_max_val   = r_max;
   assign cap_if.o_trig_addr = r_trig_addr;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: ramp, sine falling trigger, timeout, abort, gapped capture.
module tb_wave_capture;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wave_capture_if #(.DATA_W(8), .ADDR_W(7)) cap_if ();

   wave_capture #(.DATA_W(8), .ADDR_W(7), .TIMEOUT_WRAPS(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .cap_if (cap_if)
   );

   int         n_cmp = 0;
   int         n_mis = 0;
   int         g_ph  = 0;
   int         g_mode = 0;   // 0 ramp, 1 sine, 2 constant 0x10
   logic [7:0] rom [128];
   logic [7:0] d;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One generator step; invalid cycles carry junk data that must never be captured.
   task automatic stream_tick(input logic v);
      logic [7:0] smp;
      case (g_mode)
         1:       smp = rom[g_ph];
         2:       smp = 8'h10;
         default: smp = 8'(g_ph);
      endcase
      cap_if.i_sample_valid = v;
      cap_if.i_sample_in    = v ? smp : 8'hEE;
      cap_if.i_sample_addr  = 7'(g_ph);
      cap_if.i_sample_wrap  = v && (g_ph == 127);
      tick();
      if (v) g_ph = (g_ph + 1) % 128;
      cap_if.i_sample_valid = 1'b0;
      cap_if.i_sample_wrap  = 1'b0;
      cap_if.i_arm          = 1'b0;
      cap_if.i_abort        = 1'b0;
   endtask

   task automatic arm_pulse();
      cap_if.i_arm = 1'b1;
      stream_tick(1'b0);
   endtask

   task automatic rd(input int idx, output logic [7:0] q);
      cap_if.i_rd_addr = 7'(idx);
      tick();
      q = cap_if.o_rd_data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (cap_if.o_busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", cap_if.o_busy); end
      n_cmp++; if (cap_if.o_done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", cap_if.o_done); end
      n_cmp++; if (cap_if.o_timeout !== 1'b0) begin n_mis++; $display("FAIL reset_timeout: got %b want 0", cap_if.o_timeout); end
      n_cmp++; if (cap_if.o_min_val !== 8'hFF) begin n_mis++; $display("FAIL reset_min: got %h want ff", cap_if.o_min_val); end
      n_cmp++; if (cap_if.o_max_val !== 8'h00) begin n_mis++; $display("FAIL reset_max: got %h want 00", cap_if.o_max_val); end
      n_cmp++; if (cap_if.o_trig_addr !== 7'h00) begin n_mis++; $display("FAIL reset_trig_addr: got %h want 00", cap_if.o_trig_addr); end
      n_cmp++; if (cap_if.o_rd_data !== 8'h00) begin n_mis++; $display("FAIL reset_rd_data: got %h want 00", cap_if.o_rd_data); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ramp();
      g_mode = 0; g_ph = 0;
      cap_if.i_trig_level = 8'h40; cap_if.i_trig_falling = 1'b0;
      arm_pulse();
      n_cmp++; if (cap_if.o_busy !== 1'b1) begin n_mis++; $display("FAIL ramp_armed_busy: got %b want 1", cap_if.o_busy); end
      for (int i = 0; i < 64; i++) stream_tick(1'b1);
      n_cmp++; if (cap_if.o_trig_addr !== 7'h00) begin n_mis++; $display("FAIL ramp_no_early_trig: got %h want 00", cap_if.o_trig_addr); end
      stream_tick(1'b1);
      n_cmp++; if (cap_if.o_trig_addr !== 7'h40) begin n_mis++; $display("FAIL ramp_trig_addr: got %h want 40", cap_if.o_trig_addr); end
      for (int i = 0; i < 126; i++) stream_tick(1'b1);
      n_cmp++; if (cap_if.o_done !== 1'b0) begin n_mis++; $display("FAIL ramp_done_early: got %b want 0", cap_if.o_done); end
      stream_tick(1'b1);
      n_cmp++; if (cap_if.o_done !== 1'b1) begin n_mis++; $display("FAIL ramp_done: got %b want 1", cap_if.o_done); end
      n_cmp++; if (cap_if.o_busy !== 1'b0) begin n_mis++; $display("FAIL ramp_busy_done: got %b want 0", cap_if.o_busy); end
      n_cmp++; if (cap_if.o_min_val !== 8'h00) begin n_mis++; $display("FAIL ramp_min: got %h want 00", cap_if.o_min_val); end
      n_cmp++; if (cap_if.o_max_val !== 8'h7F) begin n_mis++; $display("FAIL ramp_max: got %h want 7f", cap_if.o_max_val); end
      for (int i = 0; i < 128; i++) begin
         rd(i, d);
         n_cmp++; if (d !== 8'((i + 8'h40) % 128)) begin n_mis++; $display("FAIL ramp_buf[%0d]: got %h want %h", i, d, 8'((i + 8'h40) % 128)); end
      end
   endtask

   task automatic test_sine_falling();
      g_mode = 1; g_ph = 0;
      cap_if.i_trig_level = 8'h80; cap_if.i_trig_falling = 1'b1;
      arm_pulse();
      for (int i = 0; i < 65; i++) stream_tick(1'b1);
      n_cmp++; if (cap_if.o_busy !== 1'b1) begin n_mis++; $display("FAIL sine_still_armed: got %b want 1", cap_if.o_busy); end
      stream_tick(1'b1);
      n_cmp++; if (cap_if.o_trig_addr !== 7'd65) begin n_mis++; $display("FAIL sine_trig_addr: got %0d want 65", cap_if.o_trig_addr); end
      for (int i = 0; i < 127; i++) stream_tick(1'b1);
      n_cmp++; if (cap_if.o_done !== 1'b1) begin n_mis++; $display("FAIL sine_done: got %b want 1", cap_if.o_done); end
      n_cmp++; if (cap_if.o_min_val !== 8'd1) begin n_mis++; $display("FAIL sine_min: got %0d want 1", cap_if.o_min_val); end
      n_cmp++; if (cap_if.o_max_val !== 8'd255) begin n_mis++; $display("FAIL sine_max: got %0d want 255", cap_if.o_max_val); end
      rd(0, d);
      n_cmp++; if (d !== 8'd122) begin n_mis++; $display("FAIL sine_buf0: got %0d want 122", d); end
      n_cmp++; if (!(d < 8'h80)) begin n_mis++; $display("FAIL sine_buf0_below: got %h want below 80", d); end
   endtask

   task automatic test_timeout();
      g_mode = 2; g_ph = 0;
      cap_if.i_trig_level = 8'h80; cap_if.i_trig_falling = 1'b0;
      arm_pulse();
      for (int i = 0; i < 511; i++) stream_tick(1'b1);
      n_cmp++; if (cap_if.o_busy !== 1'b1) begin n_mis++; $display("FAIL to_busy_3wraps: got %b want 1", cap_if.o_busy); end
      n_cmp++; if (cap_if.o_timeout !== 1'b0) begin n_mis++; $display("FAIL to_early: got %b want 0", cap_if.o_timeout); end
      stream_tick(1'b1);
      n_cmp++; if (cap_if.o_timeout !== 1'b1) begin n_mis++; $display("FAIL to_flag: got %b want 1", cap_if.o_timeout); end
      n_cmp++; if (cap_if.o_busy !== 1'b0) begin n_mis++; $display("FAIL to_busy: got %b want 0", cap_if.o_busy); end
      n_cmp++; if (cap_if.o_done !== 1'b0) begin n_mis++; $display("FAIL to_done: got %b want 0", cap_if.o_done); end
      for (int i = 0; i < 3; i++) stream_tick(1'b1);
      n_cmp++; if (cap_if.o_timeout !== 1'b1) begin n_mis++; $display("FAIL to_sticky: got %b want 1", cap_if.o_timeout); end
      arm_pulse();
      n_cmp++; if (cap_if.o_timeout !== 1'b0) begin n_mis++; $display("FAIL to_cleared: got %b want 0", cap_if.o_timeout); end
      n_cmp++; if (cap_if.o_busy !== 1'b1) begin n_mis++; $display("FAIL to_rearm_busy: got %b want 1", cap_if.o_busy); end
      cap_if.i_abort = 1'b1;
      stream_tick(1'b0);
      n_cmp++; if (cap_if.o_busy !== 1'b0) begin n_mis++; $display("FAIL to_abort_busy: got %b want 0", cap_if.o_busy); end
   endtask

   task automatic test_abort_rearm();
      g_mode = 0; g_ph = 0;
      cap_if.i_trig_level = 8'h40; cap_if.i_trig_falling = 1'b0;
      arm_pulse();
      for (int i = 0; i < 65; i++) stream_tick(1'b1);
      for (int i = 0; i < 49; i++) stream_tick(1'b1);
      cap_if.i_abort = 1'b1;
      stream_tick(1'b1);
      n_cmp++; if (cap_if.o_busy !== 1'b0) begin n_mis++; $display("FAIL ab_busy: got %b want 0", cap_if.o_busy); end
      n_cmp++; if (cap_if.o_done !== 1'b0) begin n_mis++; $display("FAIL ab_done: got %b want 0", cap_if.o_done); end
      arm_pulse();
      for (int i = 0; i < 77; i++) stream_tick(1'b1);
      n_cmp++; if (cap_if.o_done !== 1'b0) begin n_mis++; $display("FAIL ab_rearm_done: got %b want 0", cap_if.o_done); end
      stream_tick(1'b1);
      n_cmp++; if (cap_if.o_trig_addr !== 7'h40) begin n_mis++; $display("FAIL ab_trig_addr: got %h want 40", cap_if.o_trig_addr); end
      n_cmp++; if (cap_if.o_min_val !== 8'h40) begin n_mis++; $display("FAIL ab_fresh_min: got %h want 40", cap_if.o_min_val); end
      n_cmp++; if (cap_if.o_max_val !== 8'h40) begin n_mis++; $display("FAIL ab_fresh_max: got %h want 40", cap_if.o_max_val); end
      for (int i = 0; i < 127; i++) stream_tick(1'b1);
      n_cmp++; if (cap_if.o_done !== 1'b1) begin n_mis++; $display("FAIL ab_done_final: got %b want 1", cap_if.o_done); end
      n_cmp++; if (cap_if.o_max_val !== 8'h7F) begin n_mis++; $display("FAIL ab_max: got %h want 7f", cap_if.o_max_val); end
      rd(0, d);
      n_cmp++; if (d !== 8'h40) begin n_mis++; $display("FAIL ab_buf0: got %h want 40", d); end
      rd(50, d);
      n_cmp++; if (d !== 8'h72) begin n_mis++; $display("FAIL ab_buf50: got %h want 72", d); end
      rd(127, d);
      n_cmp++; if (d !== 8'h3F) begin n_mis++; $display("FAIL ab_buf127: got %h want 3f", d); end
   endtask

   task automatic test_valid_toggle();
      g_mode = 0; g_ph = 0;
      cap_if.i_trig_level = 8'h40; cap_if.i_trig_falling = 1'b0;
      arm_pulse();
      for (int i = 0; i < 65; i++) stream_tick(1'b1);
      for (int i = 0; i < 126; i++) begin
         stream_tick(1'b0);
         stream_tick(1'b1);
      end
      stream_tick(1'b0);
      n_cmp++; if (cap_if.o_done !== 1'b0) begin n_mis++; $display("FAIL vt_done_early: got %b want 0", cap_if.o_done); end
      stream_tick(1'b1);
      n_cmp++; if (cap_if.o_done !== 1'b1) begin n_mis++; $display("FAIL vt_done: got %b want 1", cap_if.o_done); end
      for (int i = 0; i < 128; i++) begin
         rd(i, d);
         n_cmp++; if (d !== 8'((i + 8'h40) % 128)) begin n_mis++; $display("FAIL vt_buf[%0d]: got %h want %h", i, d, 8'((i + 8'h40) % 128)); end
      end
   endtask

   task automatic test_arm_abort();
      cap_if.i_abort = 1'b1;
      stream_tick(1'b0);
      n_cmp++; if (cap_if.o_done !== 1'b0) begin n_mis++; $display("FAIL aa_done_drop: got %b want 0", cap_if.o_done); end
      cap_if.i_arm = 1'b1; cap_if.i_abort = 1'b1;
      stream_tick(1'b0);
      n_cmp++; if (cap_if.o_busy !== 1'b0) begin n_mis++; $display("FAIL aa_busy: got %b want 0", cap_if.o_busy); end
      stream_tick(1'b1);
      stream_tick(1'b1);
      n_cmp++; if (cap_if.o_busy !== 1'b0) begin n_mis++; $display("FAIL aa_stays_idle: got %b want 0", cap_if.o_busy); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cap_if.i_sample_valid = 1'b0;
      cap_if.i_sample_in    = '0;
      cap_if.i_sample_addr  = '0;
      cap_if.i_sample_wrap  = 1'b0;
      cap_if.i_arm          = 1'b0;
      cap_if.i_abort        = 1'b0;
      cap_if.i_trig_level   = '0;
      cap_if.i_trig_falling = 1'b0;
      cap_if.i_rd_addr      = '0;
      for (int i = 0; i < 128; i++)
         rom[i] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * i / 128.0) + 0.5));
      test_reset();
      test_ramp();
      test_sine_falling();
      test_timeout();
      test_abort_rearm();
      test_valid_toggle();
      test_arm_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Receive-side companion to the sign_generator datapath. It consumes the generator's sample stream: ROM data q, ROM address, and the counter wrap cout.
- It arms, waits for a level-crossing trigger, then captures DEPTH consecutive samples into an internal buffer. Min/max and trigger phase are tracked during capture.
- The buffer is read back through a registered read port. The block sits beside the generator in the top-level and gives the bench and board a self-check path.

Parameters:
- DATA_W, 8, sample width; matches ROM q.
- ADDR_W, 7, buffer index width; matches ROM address. DEPTH = 2**ADDR_W = 128.
- TIMEOUT_WRAPS, 4, number of sample_wrap events in ARMED with no trigger before the block gives up.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- sample_valid  in  1  sample qualifier; driven by the generator's cnt_en.
- sample_in  in  DATA_W  sample data (ROM q).
- sample_addr  in  ADDR_W  ROM address that goes with sample_in.
- sample_wrap  in  1  generator counter wrap (cout).
- arm  in  1  single-cycle start request.
- abort  in  1  forces the block back to IDLE.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger. Sampled while ARMED.
- rd_addr  in  ADDR_W  buffer read index.
- rd_data  out  DATA_W  buffer word, registered.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- timeout  out  1  sticky flag: trigger timed out.
- min_val  out  DATA_W  minimum of the captured samples.
- max_val  out  DATA_W  maximum of the captured samples.
- trig_addr  out  ADDR_W  sample_addr of the trigger sample.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE; busy, done, timeout = 0.
  - min_val = all-ones; max_val = 0; trig_addr = 0; rd_data = 0.
  - Internal wr_ptr = 0, prev_valid = 0, wrap_cnt = 0. Buffer contents are not reset.
- FSM has four states: IDLE, ARMED, CAPTURE, DONE.
- abort has top priority. In any state, abort=1 → IDLE next cycle, done = 0, and nothing is written that cycle. If arm and abort are both high, abort wins.
- IDLE:
  - arm → ARMED.
  - On that transition: min_val = all-ones, max_val = 0, wr_ptr = 0, prev_valid = 0, wrap_cnt = 0, timeout = 0.
- ARMED:
  - A cycle with sample_valid=1 updates prev_sample = sample_in and sets prev_valid = 1.
  - Rising trigger: prev_valid && prev_sample < trig_level && sample_in >= trig_level.
  - Falling trigger: prev_valid && prev_sample >= trig_level && sample_in < trig_level.
  - The first valid sample after arming can never trigger.
  - On trigger, in the same cycle:
    - sample_in is written to buf[0];
    - trig_addr = sample_addr;
    - min_val and max_val are updated with sample_in;
    - wr_ptr = 1; next state is CAPTURE.
  - Each cycle with sample_valid && sample_wrap and no trigger increments wrap_cnt.
  - When wrap_cnt reaches TIMEOUT_WRAPS → IDLE with timeout = 1. timeout holds until the next arm.
  - If trigger and the final wrap happen in the same cycle, the trigger wins.
  - arm is ignored in this state.
- CAPTURE:
  - Each sample_valid=1 cycle writes buf[wr_ptr], updates min_val/max_val (unsigned compare), and increments wr_ptr.
  - Cycles with sample_valid=0 are skipped: no write, no pointer change.
  - The write at wr_ptr = DEPTH-1 is the last one; next state is DONE and done = 1. wr_ptr wraps to 0.
  - sample_wrap is ignored. arm is ignored.
- DONE:
  - Holds the buffer, min_val, max_val and trig_addr.
  - arm → ARMED, with the same clears as the IDLE→ARMED transition; done drops the next cycle.
- Read port:
  - rd_data <= buf[rd_addr] every cycle, in every state: 1-cycle latency, no enable.
  - Contents are only guaranteed to be meaningful in DONE.
  - A read and a write to the same index in the same cycle returns the old data.
- Buffer: a single-write-port, single-read-port array, DEPTH × DATA_W. It must infer as block RAM.
- Capture length is exactly DEPTH samples with no gaps in index. Buffer index 0 always holds the trigger sample.

Decomposition:
- Package wave_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the state encoding (IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, DONE=2'd3);
  - the reset constants MIN_INIT = all-ones and MAX_INIT = 0.
- One sub-module, wave_buf: a simple dual-port RAM with synchronous write and registered read.
- The FSM, trigger detect, min/max and timeout logic stay in wave_capture.

Test Plan:
- Ramp 0..127 on sample_in, sample_addr = sample_in, trig_level = 8'h40, rising edge, arm once:
  - trig_addr = 7'h40;
  - done asserts 128 valid samples after the trigger;
  - buf[0..63] = 0x40..0x7F and buf[64..127] = 0x00..0x3F;
  - min_val = 0x00, max_val = 0x7F.
- Sine ROM stream with trig_level = 8'h80 and trig_falling = 1: trig_addr equals the ROM's falling-crossing address, and rd_data of index 0 (read 1 cycle later) is < 0x80.
- Constant sample_in = 0x10, trig_level = 0x80, 4 sample_wrap pulses: timeout = 1, state IDLE, busy = 0, done = 0; a later arm clears timeout.
- abort asserted mid-CAPTURE (wr_ptr = 50), then re-arm on the same ramp: busy drops next cycle, done stays 0; the capture completes normally with fresh min/max.
- sample_valid toggling 1/0 every cycle during CAPTURE: done is delayed to about 255 cycles after the trigger, and the buffer holds 128 consecutive valid samples with no duplicates.
- arm and abort asserted in the same cycle from IDLE: state stays IDLE, busy = 0.
